// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe
// MIPS execute stage with its EX/MEM pipeline register. Each cycle it selects
// forwarded operands, decodes the ALU operation, computes the ALU result,
// the branch target and the destination register, and registers them toward
// MEM. A mult is run on an iterative unsigned shift-add unit that stalls the
// upstream stage until HI/LO commit.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid, flush             ID/EX holds an instruction / squash it (and abort a mult)
//   wb_in, m_in, ex_in          control groups; ex_in = {reg_dst, alu_op[1:0], alu_src}
//   data1_in, data2_in          register-file operands A and B
//   s_extend_in                 sign-extended immediate ([5:0] funct, [10:6] shamt)
//   instr_20_16, instr_15_11    rt / rd specifiers
//   npc_in                      PC+4
//   fwd_a, fwd_b                operand source: 01 MEM, 10 WB, else register file
//   mem_fwd_data, wb_fwd_data   forwarded values
//   stall_out                   high while a mult is in progress
//   out_valid, wb_out, m_out    registered valid and controls toward MEM
//   add_result, alu_result      registered branch target / ALU result
//   write_data, dest_reg, zero  registered store data, destination, result==0

module ex_stage_pipe #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  flush,
   input  logic [1:0]            wb_in,
   input  logic [2:0]            m_in,
   input  logic [3:0]            ex_in,
   input  logic [DATA_W-1:0]     data1_in,
   input  logic [DATA_W-1:0]     data2_in,
   input  logic [DATA_W-1:0]     s_extend_in,
   input  logic [REG_ADDR_W-1:0] instr_20_16,
   input  logic [REG_ADDR_W-1:0] instr_15_11,
   input  logic [DATA_W-1:0]     npc_in,
   input  logic [1:0]            fwd_a,
   input  logic [1:0]            fwd_b,
   input  logic [DATA_W-1:0]     mem_fwd_data,
   input  logic [DATA_W-1:0]     wb_fwd_data,
   output logic                  stall_out,
   output logic                  out_valid,
   output logic [1:0]            wb_out,
   output logic [2:0]            m_out,
   output logic [DATA_W-1:0]     add_result,
   output logic [DATA_W-1:0]     alu_result,
   output logic [DATA_W-1:0]     write_data,
   output logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  zero
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_NOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_MFHI = 4'd8,
      OP_MFLO = 4'd9,
      OP_MULT = 4'd10,
      OP_NONE = 4'd11
   } alu_sel_t;

   logic                  w_alu_src;
   logic                  w_reg_dst;
   logic [1:0]            w_alu_op;
   logic [5:0]            w_funct;
   logic [4:0]            w_shamt;
   logic [DATA_W-1:0]     w_opa;
   logic [DATA_W-1:0]     w_fwd_b;
   logic [DATA_W-1:0]     w_opb;
   logic [DATA_W-1:0]     w_alu;
   logic [DATA_W-1:0]     w_target;
   logic [REG_ADDR_W-1:0] w_dest;
   alu_sel_t              w_sel;
   logic                  w_is_mult;
   logic                  w_transfer;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_mul_start;
   logic                  w_mul_step;
   logic                  w_mul_done;
   logic [CNT_W-1:0]      r_cnt;
   logic [2*DATA_W-1:0]   r_mcand;
   logic [2*DATA_W-1:0]   r_acc;
   logic [2*DATA_W-1:0]   w_product;
   logic [DATA_W-1:0]     r_mplier;
   logic [DATA_W-1:0]     r_hi;
   logic [DATA_W-1:0]     r_lo;

   assign w_alu_src = ex_in[0];
   assign w_alu_op  = ex_in[2:1];
   assign w_reg_dst = ex_in[3];
   assign w_funct   = s_extend_in[5:0];

   // Narrow datapaths have no bits above the immediate's top, so the shamt
   // field is zero-extended from whatever part of [10:6] exists.
   if (DATA_W >= 11) begin : g_shamt_full
      assign w_shamt = s_extend_in[10:6];
   end else begin : g_shamt_part
      assign w_shamt = {{(11-DATA_W){1'b0}}, s_extend_in[DATA_W-1:6]};
   end

   // Forwarding muxes for operands A and B
   always_comb begin
      w_opa   = data1_in;
      w_fwd_b = data2_in;
      case (fwd_a)
         2'b01:   w_opa = mem_fwd_data;
         2'b10:   w_opa = wb_fwd_data;
         default: w_opa = data1_in;
      endcase
      case (fwd_b)
         2'b01:   w_fwd_b = mem_fwd_data;
         2'b10:   w_fwd_b = wb_fwd_data;
         default: w_fwd_b = data2_in;
      endcase
   end

   assign w_opb    = w_alu_src ? s_extend_in : w_fwd_b;
   assign w_target = npc_in + {s_extend_in[DATA_W-3:0], 2'b00};
   assign w_dest   = w_reg_dst ? instr_15_11 : instr_20_16;

   // ALU control decode from alu_op and funct
   always_comb begin
      w_sel = OP_NONE;
      case (w_alu_op)
         2'b00: w_sel = OP_ADD;
         2'b01: w_sel = OP_SUB;
         2'b11: w_sel = OP_SLT;
         default: begin
            case (w_funct)
               6'h20:   w_sel = OP_ADD;
               6'h22:   w_sel = OP_SUB;
               6'h24:   w_sel = OP_AND;
               6'h25:   w_sel = OP_OR;
               6'h27:   w_sel = OP_NOR;
               6'h2A:   w_sel = OP_SLT;
               6'h00:   w_sel = OP_SLL;
               6'h02:   w_sel = OP_SRL;
               6'h10:   w_sel = OP_MFHI;
               6'h12:   w_sel = OP_MFLO;
               6'h18:   w_sel = OP_MULT;
               default: w_sel = OP_NONE;
            endcase
         end
      endcase
   end

   // ALU result; mult and unknown functs yield zero here
   always_comb begin
      w_alu = {DATA_W{1'b0}};
      case (w_sel)
         OP_ADD:  w_alu = w_opa + w_opb;
         OP_SUB:  w_alu = w_opa - w_opb;
         OP_AND:  w_alu = w_opa & w_opb;
         OP_OR:   w_alu = w_opa | w_opb;
         OP_NOR:  w_alu = ~(w_opa | w_opb);
         OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
         OP_SLL:  w_alu = w_opb << w_shamt;
         OP_SRL:  w_alu = w_opb >> w_shamt;
         OP_MFHI: w_alu = r_hi;
         OP_MFLO: w_alu = r_lo;
         default: w_alu = {DATA_W{1'b0}};
      endcase
   end

   assign w_is_mult  = (w_sel == OP_MULT);
   assign stall_out  = (r_state == S_MUL);
   assign w_transfer = in_valid & ~stall_out & ~flush;

   // Partial product including the current multiplier bit; on the final step
   // this is the full 2*DATA_W-bit product.
   assign w_product = r_acc + (r_mplier[0] ? r_mcand : {(2*DATA_W){1'b0}});

   // Next-state and multiplier sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_mul_start = 1'b0;
      w_mul_step  = 1'b0;
      w_mul_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_transfer && w_is_mult) begin
               w_mul_start = 1'b1;
               w_state_nxt = S_MUL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_mul_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_mul_step  = 1'b1;
               w_state_nxt = S_MUL;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift-add multiplier: multiplicand shifts left, multiplier shifts right
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= {(2*DATA_W){1'b0}};
         r_mplier <= {DATA_W{1'b0}};
         r_acc    <= {(2*DATA_W){1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_mul_start) begin
         r_mcand  <= {{DATA_W{1'b0}}, w_opa};
         r_mplier <= w_fwd_b;
         r_acc    <= {(2*DATA_W){1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_mul_step) begin
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_acc    <= w_product;
         r_cnt    <= r_cnt + CNT_ONE;
      end else begin
         r_mcand  <= r_mcand;
         r_mplier <= r_mplier;
         r_acc    <= r_acc;
         r_cnt    <= r_cnt;
      end
   end

   // HI/LO commit only on a completed (non-aborted) mult
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= {DATA_W{1'b0}};
         r_lo <= {DATA_W{1'b0}};
      end else if (w_mul_done) begin
         r_hi <= w_product[2*DATA_W-1:DATA_W];
         r_lo <= w_product[DATA_W-1:0];
      end else begin
         r_hi <= r_hi;
         r_lo <= r_lo;
      end
   end

   // EX/MEM register: mult retirement, normal transfer, or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         wb_out     <= 2'b00;
         m_out      <= 3'b000;
         add_result <= {DATA_W{1'b0}};
         alu_result <= {DATA_W{1'b0}};
         write_data <= {DATA_W{1'b0}};
         dest_reg   <= {REG_ADDR_W{1'b0}};
         zero       <= 1'b0;
      end else if (w_mul_done) begin
         // A retiring mult carries no writeback/memory side effects.
         out_valid  <= 1'b1;
         wb_out     <= 2'b00;
         m_out      <= 3'b000;
         alu_result <= w_product[DATA_W-1:0];
         zero       <= (w_product[DATA_W-1:0] == {DATA_W{1'b0}});
      end else if (w_transfer && !w_is_mult) begin
         out_valid  <= 1'b1;
         wb_out     <= wb_in;
         m_out      <= m_in;
         add_result <= w_target;
         alu_result <= w_alu;
         write_data <= w_fwd_b;
         dest_reg   <= w_dest;
         zero       <= (w_alu == {DATA_W{1'b0}});
      end else begin
         out_valid  <= 1'b0;
         wb_out     <= 2'b00;
         m_out      <= 3'b000;
      end
   end

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;

   logic        clk;
   logic        rst;

   // 32-bit instance stimulus and observation
   logic        iv, fl;
   logic [1:0]  wbi;
   logic [2:0]  mi;
   logic [3:0]  exi;
   logic [31:0] d1, d2, imm, npc, mf, wf;
   logic [4:0]  rt, rd;
   logic [1:0]  fa, fb;
   logic        stall_out, out_valid, zero;
   logic [1:0]  wb_out;
   logic [2:0]  m_out;
   logic [31:0] add_result, alu_result, write_data;
   logic [4:0]  dest_reg;

   // 8-bit instance
   logic        e_iv;
   logic [3:0]  e_exi;
   logic [7:0]  e_d1, e_d2, e_imm;
   logic        e_stall, e_valid, e_zero;
   logic [1:0]  e_wb;
   logic [2:0]  e_m;
   logic [7:0]  e_add, e_alu, e_wd;
   logic [4:0]  e_dest;

   int          n_checks;
   int          n_err;
   logic [31:0] m_hi, m_lo;   // reference HI/LO
   logic [5:0]  fn_tab [0:11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                                  6'h00, 6'h02, 6'h10, 6'h12, 6'h3F, 6'h01};

   ex_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(iv), .flush(fl), .wb_in(wbi), .m_in(mi),
      .ex_in(exi), .data1_in(d1), .data2_in(d2), .s_extend_in(imm),
      .instr_20_16(rt), .instr_15_11(rd), .npc_in(npc), .fwd_a(fa), .fwd_b(fb),
      .mem_fwd_data(mf), .wb_fwd_data(wf), .stall_out(stall_out),
      .out_valid(out_valid), .wb_out(wb_out), .m_out(m_out),
      .add_result(add_result), .alu_result(alu_result), .write_data(write_data),
      .dest_reg(dest_reg), .zero(zero)
   );

   ex_stage_pipe #(.DATA_W(8), .REG_ADDR_W(5)) dut8 (
      .clk(clk), .rst(rst), .in_valid(e_iv), .flush(1'b0), .wb_in(2'b00), .m_in(3'b000),
      .ex_in(e_exi), .data1_in(e_d1), .data2_in(e_d2), .s_extend_in(e_imm),
      .instr_20_16(5'd0), .instr_15_11(5'd0), .npc_in(8'd0), .fwd_a(2'b00), .fwd_b(2'b00),
      .mem_fwd_data(8'd0), .wb_fwd_data(8'd0), .stall_out(e_stall),
      .out_valid(e_valid), .wb_out(e_wb), .m_out(e_m),
      .add_result(e_add), .alu_result(e_alu), .write_data(e_wd),
      .dest_reg(e_dest), .zero(e_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] mem, input logic [31:0] wbv);
      if (sel == 2'b01) return mem;
      if (sel == 2'b10) return wbv;
      return rf;
   endfunction

   // Reference ALU written from the operation table
   function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn,
                                           input logic [4:0] sh, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
      logic signed [32:0] sa, sb;
      sa = {a[31], a};
      sb = {b[31], b};
      if (aop == 2'b00) return a + b;
      if (aop == 2'b01) return a - b;
      if (aop == 2'b11) return (sa < sb) ? 32'd1 : 32'd0;
      case (fn)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h27:   return ~(a | b);
         6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
         6'h00:   return b << sh;
         6'h02:   return b >> sh;
         6'h10:   return hi;
         6'h12:   return lo;
         default: return 32'd0;
      endcase
   endfunction

   // One non-mult instruction from the currently driven inputs, checked one edge later
   task automatic exec_check(input string tag);
      logic [31:0] a, bf, b, res, tgt;
      logic [4:0]  dst;
      logic        xfer;
      a    = pick(fa, d1, mf, wf);
      bf   = pick(fb, d2, mf, wf);
      b    = exi[0] ? imm : bf;
      res  = ref_alu(exi[2:1], imm[5:0], imm[10:6], a, b, m_hi, m_lo);
      tgt  = npc + imm * 32'd4;
      dst  = exi[3] ? rd : rt;
      xfer = iv && !fl;
      @(posedge clk); #1;
      chk({tag, ":valid"}, out_valid, xfer);
      chk({tag, ":wb"}, wb_out, xfer ? wbi : 2'b00);
      chk({tag, ":m"}, m_out, xfer ? mi : 3'b000);
      if (xfer) begin
         chk({tag, ":alu"}, alu_result, res);
         chk({tag, ":target"}, add_result, tgt);
         chk({tag, ":store"}, write_data, bf);
         chk({tag, ":dest"}, dest_reg, dst);
         chk({tag, ":zero"}, zero, res == 32'd0);
      end
   endtask

   // Issue a mult from the driven operands; optionally hold an mfhi behind it
   task automatic do_mult(input string tag, input bit hold_mfhi);
      logic [31:0] a, b;
      logic [63:0] p;
      int          n, bad;
      a   = pick(fa, d1, mf, wf);
      b   = pick(fb, d2, mf, wf);
      p   = {32'd0, a} * {32'd0, b};
      iv  = 1'b1; fl = 1'b0;
      exi = 4'b0100; imm = 32'h0000_0018;
      @(posedge clk); #1;
      chk({tag, ":start_bubble"}, out_valid, 1'b0);
      if (hold_mfhi) begin
         exi = 4'b1100; imm = 32'h0000_0010; wbi = 2'b10; mi = 3'b001; rd = 5'd9;
      end else begin
         iv = 1'b0;
      end
      n = 0; bad = 0;
      for (int i = 0; i < 100 && stall_out; i++) begin
         if (out_valid) bad++;
         n++;
         @(posedge clk); #1;
      end
      chk({tag, ":stall_cycles"}, n, 32);
      chk({tag, ":stall_bubbles"}, bad, 0);
      chk({tag, ":retire_valid"}, out_valid, 1'b1);
      chk({tag, ":retire_ctl"}, {wb_out, m_out}, 5'd0);
      m_hi = p[63:32];
      m_lo = p[31:0];
   endtask

   task automatic set_op(input logic rdst, input logic [1:0] aop, input logic src,
                         input logic [31:0] fieldv);
      exi = {rdst, aop, src};
      imm = fieldv;
   endtask

   initial begin
      int n, bad;
      n_checks = 0; n_err = 0; m_hi = 32'd0; m_lo = 32'd0;
      rst = 1'b1; iv = 1'b0; fl = 1'b0; wbi = 2'b00; mi = 3'b000; exi = 4'b0000;
      d1 = 32'd0; d2 = 32'd0; imm = 32'd0; npc = 32'd0; mf = 32'd0; wf = 32'd0;
      rt = 5'd0; rd = 5'd0; fa = 2'b00; fb = 2'b00;
      e_iv = 1'b0; e_exi = 4'b0000; e_d1 = 8'd0; e_d2 = 8'd0; e_imm = 8'd0;

      // Reset state
      #12;
      chk("reset_ctl", {stall_out, out_valid, wb_out, m_out, zero, dest_reg}, 64'd0);
      chk("reset_data", {add_result, alu_result}, 64'd0);
      chk("reset_store", write_data, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // add with A forwarded from MEM
      iv = 1'b1; wbi = 2'b10; mi = 3'b000; rt = 5'd3; rd = 5'd4;
      fa = 2'b01; mf = 32'd7; d1 = 32'd99; fb = 2'b00; d2 = 32'd5;
      set_op(1'b1, 2'b10, 1'b0, 32'h0000_0020);
      exec_check("add_fwd");
      chk("add_fwd_value", alu_result, 32'd12);

      // beq-style compare and branch target
      fa = 2'b00; d1 = 32'h1234; d2 = 32'h1234; npc = 32'h100; wbi = 2'b00; mi = 3'b100;
      set_op(1'b0, 2'b01, 1'b0, 32'd3);
      exec_check("beq");
      chk("beq_zero", zero, 1'b1);
      chk("beq_target", add_result, 32'h10C);

      // sll B by 4
      d2 = 32'd1; wbi = 2'b10; mi = 3'b000;
      set_op(1'b1, 2'b10, 1'b0, (32'd4 << 6));
      exec_check("sll");
      chk("sll_value", alu_result, 32'h10);

      // signed slt: -1 < 1
      d1 = 32'hFFFF_FFFF; d2 = 32'd1;
      set_op(1'b1, 2'b10, 1'b0, 32'h0000_002A);
      exec_check("slt");
      chk("slt_value", alu_result, 32'd1);

      // Randomized non-mult traffic with occasional idles and flushes
      for (int k = 0; k < 80; k++) begin
         logic [1:0] aop;
         aop = 2'($urandom_range(0, 3));
         d1 = $urandom; d2 = $urandom; mf = $urandom; wf = $urandom; npc = $urandom;
         fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
         rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
         wbi = 2'($urandom_range(0, 3)); mi = 3'($urandom_range(0, 7));
         iv = ($urandom_range(0, 7) != 0); fl = ($urandom_range(0, 9) == 0);
         imm = $urandom;
         if (aop == 2'b10) imm[5:0] = fn_tab[$urandom_range(0, 11)];
         exi = {1'($urandom_range(0, 1)), aop, 1'($urandom_range(0, 1))};
         exec_check("rand");
      end
      fl = 1'b0;

      // mult 0xFFFFFFFF x 2 with mfhi waiting behind it
      fa = 2'b00; fb = 2'b00; d1 = 32'hFFFF_FFFF; d2 = 32'd2;
      do_mult("mult_max", 1'b1);
      exec_check("mfhi_after_mult");
      chk("mfhi_value", alu_result, 32'd1);
      set_op(1'b1, 2'b10, 1'b0, 32'h0000_0012);
      exec_check("mflo_after_mult");
      chk("mflo_value", alu_result, 32'hFFFF_FFFE);

      // Random mults through forwarding paths
      for (int k = 0; k < 3; k++) begin
         d1 = $urandom; d2 = $urandom; mf = $urandom; wf = $urandom;
         fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
         do_mult("mult_rand", 1'b0);
         iv = 1'b1; set_op(1'b1, 2'b10, 1'b0, 32'h0000_0010);
         exec_check("mult_rand_hi");
         set_op(1'b1, 2'b10, 1'b0, 32'h0000_0012);
         exec_check("mult_rand_lo");
      end

      // Flush during MUL cycle 10: abort, HI/LO unchanged
      fa = 2'b00; fb = 2'b00; d1 = 32'd3; d2 = 32'd5; iv = 1'b1;
      set_op(1'b0, 2'b10, 1'b0, 32'h0000_0018);
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("flush_mul_stalling", stall_out, 1'b1);
      fl = 1'b1;
      @(posedge clk); #1;
      fl = 1'b0;
      chk("flush_mul_stall_drop", stall_out, 1'b0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) bad++;
         @(posedge clk); #1;
      end
      chk("flush_mul_no_valid", bad, 0);
      iv = 1'b1; set_op(1'b1, 2'b10, 1'b0, 32'h0000_0010);
      exec_check("flush_keep_hi");
      set_op(1'b1, 2'b10, 1'b0, 32'h0000_0012);
      exec_check("flush_keep_lo");

      // Flush while idle with a valid input
      fl = 1'b1; set_op(1'b1, 2'b10, 1'b0, 32'h0000_0020);
      exec_check("flush_idle");
      fl = 1'b0;

      // Reset mid-multiply is asynchronous and discards the operation
      d1 = 32'd77; d2 = 32'd88; set_op(1'b0, 2'b10, 1'b0, 32'h0000_0018);
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1; #1;
      chk("rst_mid_ctl", {stall_out, out_valid, wb_out, m_out, zero, dest_reg}, 64'd0);
      chk("rst_mid_data", {add_result, alu_result}, 64'd0);
      chk("rst_mid_store", write_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
      iv = 1'b1; set_op(1'b1, 2'b10, 1'b0, 32'h0000_0012);
      exec_check("rst_mflo");
      chk("rst_mflo_value", alu_result, 32'd0);
      set_op(1'b1, 2'b10, 1'b0, 32'h0000_0010);
      exec_check("rst_mfhi");
      iv = 1'b0;

      // DATA_W = 8: 0xFF x 0xFF = 0xFE01
      e_d1 = 8'hFF; e_d2 = 8'hFF; e_exi = 4'b0100; e_imm = 8'h18; e_iv = 1'b1;
      @(posedge clk); #1;
      e_iv = 1'b0;
      n = 0;
      for (int i = 0; i < 50 && e_stall; i++) begin
         n++;
         @(posedge clk); #1;
      end
      chk("w8_stall_cycles", n, 8);
      chk("w8_retire_valid", e_valid, 1'b1);
      e_exi = 4'b1100; e_imm = 8'h10; e_iv = 1'b1;
      @(posedge clk); #1;
      chk("w8_mfhi", {e_valid, e_alu}, {1'b1, 8'hFE});
      e_imm = 8'h12;
      @(posedge clk); #1;
      chk("w8_mflo", {e_valid, e_alu}, {1'b1, 8'h01});
      e_iv = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
